fuzzy_risk_seq: RTL and testbench
=================================

Name: fuzzy_risk_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle rainfall/soil fuzzy risk estimator.
- Accepts one (rain, soil) sample per valid/ready handshake.
- Fuzzifies each input with three configurable triangular sets, fires three min-AND rules, and defuzzifies by weighted average.
- The division runs on an iterative restoring divider, so no combinational divide sits on the datapath.
- Sits between the sensor front-end and the risk alarm/comparator logic.

Parameters:
- DW, 8, input sample width.
- IN_MAX, 100, inputs above this are clamped to IN_MAX before fuzzification.
- LO_A, LO_B, LO_C, 0/20/40, low-set breakpoints.
- MD_A, MD_B, MD_C, 30/50/70, medium-set breakpoints.
- HI_A, HI_B, HI_C, 60/80/100, high-set breakpoints.
- W_LO, W_MD, W_HI, 85/170/255, rule consequent weights (8-bit each).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  sample valid
- in_ready  out  1  block idle, can accept a sample
- rain  in  DW  rainfall sample
- soil  in  DW  soil-moisture sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- risk  out  8  defuzzified risk, 0..255
- no_fire  out  1  high with out_valid when all rule strengths are 0

Behaviour:
- Reset (rst high at a clk edge): state IDLE; in_ready=1, out_valid=0, risk=0, no_fire=0; all internal registers cleared. Reset wins over every other event, including mid-DIV. Any in-flight sample is discarded and produces no output.
- State machine: IDLE -> FUZZ -> RULE -> ACC -> DIV -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0, capture min(rain,IN_MAX) and min(soil,IN_MAX), then go to FUZZ.
- FUZZ (edge E1): register six memberships, 8-bit each, using the triangular rule for a set (a,b,c) and value v:
  - v<=a -> 0
  - v<=b -> floor((v-a)*255/(b-a))
  - v<=c -> floor((c-v)*255/(c-b))
  - otherwise 0
  - Divisors are elaboration-time constants. b==a or c==b is illegal (elaboration assertion).
- RULE (E2): register three rule strengths:
  - s_hi = min(rain_hi, soil_hi)
  - s_md = min(rain_md, soil_md)
  - s_lo = min(rain_lo, soil_lo)
  - AND is min, not bitwise.
- ACC (E3):
  - num = s_hi*W_HI + s_md*W_MD + s_lo*W_LO, 18 bits.
  - den = s_hi + s_md + s_lo, 10 bits.
  - If den==0: go to DONE with risk=0, no_fire=1.
  - Otherwise go to DIV with bit counter=7.
- DIV (E4..E11): restoring division, one quotient bit per cycle, MSB first, 8 iterations.
  - The quotient always fits in 8 bits, since the weighted average is at most max weight 255.
  - Result is floor(num/den).
  - At E11: risk=quotient, no_fire=0, go to DONE.
- DONE:
  - out_valid=1; risk and no_fire held stable while out_ready=0 (no limit on stall).
  - On out_valid&out_ready: out_valid=0, go to IDLE. risk keeps its last value until the next result.
- Latency:
  - Normal path: out_valid rises after E11, i.e. 11 cycles after the input handshake edge.
  - no_fire path: out_valid rises after E3.
- Throughput: one sample in flight. in_ready=0 in every state except IDLE, so in_valid is ignored outside IDLE.
- Back-to-back: a new sample is accepted no earlier than the cycle after the output handshake. There is no combinational in_ready<-out_ready path.

Test Plan:
- Reset then rain=80, soil=80, out_ready=1 -> s_hi=255, num=65025, den=255; out_valid 11 cycles after accept, risk=255, no_fire=0.
- rain=50, soil=50 -> risk=170. rain=20, soil=20 -> risk=85. rain=200, soil=200 -> both clamped to 100, all memberships 0 -> no_fire=1, risk=0.
- rain=35, soil=35 -> lo=md=63; num=16065, den=126 -> risk=127 (floor check).
- rain=50, soil=80 -> all strengths 0 -> no_fire=1, risk=0, out_valid 3 cycles after accept.
- Hold out_ready=0 for 20 cycles after out_valid with in_valid=1 and changing inputs -> risk stable, in_ready=0, no new sample taken. Release -> one handshake, then in_ready=1 next cycle.
- Assert rst during DIV (cycle 6 after accept) -> next cycle out_valid=0, risk=0, in_ready=1, and no result is ever emitted for that sample.

Source files
------------

// File: rtl/fuzzy_risk_seq.sv
// fuzzy_risk_seq
//   Multi-cycle fuzzy flood-risk estimator.
//   One (rain, soil) sample is taken per valid/ready handshake. Each input is
//   clamped, fuzzified with three triangular sets (low/medium/high), three
//   min-AND rules are fired, and the result is defuzzified by a weighted
//   average. The average is computed on an 8-step restoring divider.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   in_valid   sample valid
//   in_ready   block idle and able to accept a sample
//   rain       rainfall sample (DW bits)
//   soil       soil-moisture sample (DW bits)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   risk       defuzzified risk, 0..255
//   no_fire    high with the result when every rule strength is 0
module fuzzy_risk_seq #(
    parameter int DW     = 8,
    parameter int IN_MAX = 100,
    parameter int LO_A   = 0,
    parameter int LO_B   = 20,
    parameter int LO_C   = 40,
    parameter int MD_A   = 30,
    parameter int MD_B   = 50,
    parameter int MD_C   = 70,
    parameter int HI_A   = 60,
    parameter int HI_B   = 80,
    parameter int HI_C   = 100,
    parameter int W_LO   = 85,
    parameter int W_MD   = 170,
    parameter int W_HI   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] rain,
    input  logic [DW-1:0] soil,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    risk,
    output logic          no_fire
);

    // A flat shoulder would make the slope divisor zero.
    if ((LO_B == LO_A) || (LO_C == LO_B) ||
        (MD_B == MD_A) || (MD_C == MD_B) ||
        (HI_B == HI_A) || (HI_C == HI_B)) begin : g_bad_sets
        $error("fuzzy_risk_seq: triangular set with zero-width slope");
    end

    typedef enum logic [2:0] {IDLE, FUZZ, RULE, ACC, DIV, DONE} state_t;

    localparam logic [DW-1:0] IN_MAX_C = DW'(IN_MAX);
    localparam logic [17:0]   WL = 18'(W_LO);
    localparam logic [17:0]   WM = 18'(W_MD);
    localparam logic [17:0]   WH = 18'(W_HI);

    state_t state, state_next;

    logic [DW-1:0] rain_q, soil_q;
    logic [7:0]    rain_lo, rain_md, rain_hi;
    logic [7:0]    soil_lo, soil_md, soil_hi;
    logic [7:0]    s_lo, s_md, s_hi;
    logic [17:0]   rem, dvs;
    logic [7:0]    quo;
    logic [2:0]    cnt;

    logic [DW-1:0] rain_c, soil_c;
    logic [17:0]   num_c;
    logic [9:0]    den_c;
    logic          ge;
    logic [7:0]    quo_next;

    // Triangular membership; the slope divisors are constants after elaboration.
    function automatic logic [7:0] tri_mf(input logic [DW-1:0] v,
                                          input int a, input int b, input int c);
        int vi;
        int r;
        vi = int'(v);
        if (vi <= a)
            r = 0;
        else if (vi <= b)
            r = ((vi - a) * 255) / (b - a);
        else if (vi <= c)
            r = ((c - vi) * 255) / (c - b);
        else
            r = 0;
        return r[7:0];
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] x, input logic [7:0] y);
        return (x < y) ? x : y;
    endfunction

    assign rain_c = (rain > IN_MAX_C) ? IN_MAX_C : rain;
    assign soil_c = (soil > IN_MAX_C) ? IN_MAX_C : soil;

    assign num_c = {10'd0, s_hi} * WH + {10'd0, s_md} * WM + {10'd0, s_lo} * WL;
    assign den_c = {2'd0, s_hi} + {2'd0, s_md} + {2'd0, s_lo};

    // The divisor register starts at den<<7 and walks right one bit per step,
    // so each step decides one quotient bit, MSB first.
    assign ge       = (rem >= dvs);
    assign quo_next = {quo[6:0], ge};

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs; both handshake outputs depend only on
    // the state, so there is no combinational in_ready<-out_ready path.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = FUZZ;
            end
            FUZZ: state_next = RULE;
            RULE: state_next = ACC;
            ACC:  state_next = (den_c == 10'd0) ? DONE : DIV;
            DIV:  state_next = (cnt == 3'd0) ? DONE : DIV;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: each stage is loaded only in its own state, so risk/no_fire
    // keep the last result until a new one is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            rain_q  <= '0;
            soil_q  <= '0;
            rain_lo <= '0;
            rain_md <= '0;
            rain_hi <= '0;
            soil_lo <= '0;
            soil_md <= '0;
            soil_hi <= '0;
            s_lo    <= '0;
            s_md    <= '0;
            s_hi    <= '0;
            rem     <= '0;
            dvs     <= '0;
            quo     <= '0;
            cnt     <= '0;
            risk    <= '0;
            no_fire <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rain_q <= rain_c;
                        soil_q <= soil_c;
                    end
                end
                FUZZ: begin
                    rain_lo <= tri_mf(rain_q, LO_A, LO_B, LO_C);
                    rain_md <= tri_mf(rain_q, MD_A, MD_B, MD_C);
                    rain_hi <= tri_mf(rain_q, HI_A, HI_B, HI_C);
                    soil_lo <= tri_mf(soil_q, LO_A, LO_B, LO_C);
                    soil_md <= tri_mf(soil_q, MD_A, MD_B, MD_C);
                    soil_hi <= tri_mf(soil_q, HI_A, HI_B, HI_C);
                end
                RULE: begin
                    s_lo <= min8(rain_lo, soil_lo);
                    s_md <= min8(rain_md, soil_md);
                    s_hi <= min8(rain_hi, soil_hi);
                end
                ACC: begin
                    if (den_c == 10'd0) begin
                        risk    <= 8'd0;
                        no_fire <= 1'b1;
                    end else begin
                        rem <= num_c;
                        dvs <= {1'b0, den_c, 7'd0};
                        quo <= 8'd0;
                        cnt <= 3'd7;
                    end
                end
                DIV: begin
                    if (ge)
                        rem <= rem - dvs;
                    dvs <= dvs >> 1;
                    quo <= quo_next;
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        risk    <= quo_next;
                        no_fire <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_risk_seq.sv
// tb_fuzzy_risk_seq
//   Self-checking bench for fuzzy_risk_seq. A cycle-count model computes the
//   expected risk directly from the fuzzy rules and tracks when the result
//   must appear; a negedge compare process checks every DUT output against
//   it each cycle. Directed vectors also pin the model to hand-computed
//   literal results.
module tb_fuzzy_risk_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rain;
    logic [7:0] soil;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] risk;
    logic       no_fire;

    int total = 0;
    int bad   = 0;

    // Model state
    bit checking = 1'b0;
    bit m_busy   = 1'b0;
    int m_cnt    = 0;
    int m_lat    = 0;
    int m_risk   = 0;
    int m_nf     = 0;
    int shown_risk = 0;
    int shown_nf   = 0;

    fuzzy_risk_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rain      (rain),
        .soil      (soil),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .risk      (risk),
        .no_fire   (no_fire)
    );

    always #5 clk = ~clk;

    function automatic int mf(input int v, input int a, input int b, input int c);
        if (v <= a) return 0;
        if (v <= b) return ((v - a) * 255) / (b - a);
        if (v <= c) return ((c - v) * 255) / (c - b);
        return 0;
    endfunction

    // Fuzzy risk straight from the rules: clamp, memberships, min-AND, weighted average.
    task automatic model_eval(input int r, input int s, output int rk, output int nf, output int lat);
        int rv, sv, num, den, st;
        int rm[3];
        int sm[3];
        int w[3];
        w[0] = 85; w[1] = 170; w[2] = 255;
        rv = (r > 100) ? 100 : r;
        sv = (s > 100) ? 100 : s;
        rm[0] = mf(rv, 0, 20, 40);  sm[0] = mf(sv, 0, 20, 40);
        rm[1] = mf(rv, 30, 50, 70); sm[1] = mf(sv, 30, 50, 70);
        rm[2] = mf(rv, 60, 80, 100); sm[2] = mf(sv, 60, 80, 100);
        num = 0;
        den = 0;
        for (int i = 0; i < 3; i++) begin
            st  = (rm[i] < sm[i]) ? rm[i] : sm[i];
            num += st * w[i];
            den += st;
        end
        if (den == 0) begin
            rk = 0; nf = 1; lat = 3;
        end else begin
            rk = num / den; nf = 0; lat = 11;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out waiting, got none, expected event at %0t", name, $time);
    endtask

    // Model advances on every rising edge from the inputs alone.
    always @(posedge clk) begin
        checking = 1'b1;
        if (rst) begin
            m_busy     = 1'b0;
            m_cnt      = 0;
            shown_risk = 0;
            shown_nf   = 0;
        end else if (m_busy) begin
            if (m_cnt >= m_lat) begin
                if (out_ready)
                    m_busy = 1'b0;
            end else begin
                m_cnt++;
                if (m_cnt == m_lat) begin
                    shown_risk = m_risk;
                    shown_nf   = m_nf;
                end
            end
        end else if (in_valid) begin
            model_eval(int'(rain), int'(soil), m_risk, m_nf, m_lat);
            m_busy = 1'b1;
            m_cnt  = 0;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("cyc_in_ready", int'(in_ready), int'(!m_busy));
            check("cyc_out_valid", int'(out_valid), int'(m_busy && (m_cnt >= m_lat)));
            check("cyc_risk", int'(risk), shown_risk);
            check("cyc_no_fire", int'(no_fire), shown_nf);
        end
    end

    // Offer one sample, wait for acceptance, then measure cycles to out_valid.
    task automatic applyStimulus(input int r, input int s, output int lat);
        int guard;
        @(negedge clk);
        rain     = r[7:0];
        soil     = s[7:0];
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) timeout_fail("accept");
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) timeout_fail("out_valid");
    endtask

    task automatic checkOutput(input string name, input int r, input int s,
                               input int exp_risk, input int exp_nf,
                               input int exp_lat, input int lat);
        int mr, mn, ml;
        model_eval(r, s, mr, mn, ml);
        check({name, "_model_risk"}, mr, exp_risk);
        check({name, "_model_nf"}, mn, exp_nf);
        check({name, "_model_lat"}, ml, exp_lat);
        check({name, "_risk"}, int'(risk), exp_risk);
        check({name, "_no_fire"}, int'(no_fire), exp_nf);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    int vr[6];
    int vs[6];
    int vk[6];
    int vn[6];
    int vl[6];
    int lat;
    int seen;

    initial begin
        vr = '{80, 50, 20, 200, 35, 50};
        vs = '{80, 50, 20, 200, 35, 80};
        vk = '{255, 170, 85, 0, 127, 0};
        vn = '{0, 0, 0, 1, 0, 1};
        vl = '{11, 11, 11, 3, 11, 3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rain      = 8'd0;
        soil      = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_risk", int'(risk), 0);
        check("rst_no_fire", int'(no_fire), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vr[i], vs[i], lat);
            checkOutput($sformatf("vec%0d", i), vr[i], vs[i], vk[i], vn[i], vl[i], lat);
        end

        // Output stall with a busy upstream offering changing samples.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(50, 50, lat);
        checkOutput("stall", 50, 50, 170, 0, 11, lat);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            rain     = 8'(i * 7);
            soil     = 8'(90 - i * 3);
            @(negedge clk);
            check("stall_risk", int'(risk), 170);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", int'(in_ready), 1);
        check("release_out_valid", int'(out_valid), 0);
        check("release_risk", int'(risk), 170);

        // Reset while the divider is running.
        rain     = 8'd80;
        soil     = 8'd80;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_risk", int'(risk), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_output", seen, 0);

        // Recovery after the aborted sample.
        applyStimulus(20, 20, lat);
        checkOutput("recover", 20, 20, 85, 0, 11, lat);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
